aes_key_schedule_seq: RTL and testbench

Sequential, runtime-configurable AES key expansion supporting 128-, 192- and 256-bit keys. It generates one schedule word per clock through a single shared 4-byte S-box and stores the full schedule in an internal word array. A round-key read port serves the cipher datapath. It replaces a fully combinational expansion with an area-lean iterative engine that uses a start/busy/done handshake.

---
 rtl/aes_key_schedule_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_aes_key_schedule_seq.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128/192/256 key expansion: one schedule word per clock through a shared
// 4-byte S-box. Define AES_KS_INV_KEYS_EN to add rk_inv (InvMixColumns on the read path).
module aes_key_schedule_seq #(
    parameter int MAX_NK   = 8,
    parameter int RK_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           key_len,
    input  logic [32*MAX_NK-1:0] key,
    output logic                 busy,
    output logic                 done,
    output logic                 key_valid,
    output logic                 err,
    output logic [3:0]           nr,
`ifdef AES_KS_INV_KEYS_EN
    input  logic                 rk_inv,
`endif
    input  logic [RK_IDX_W-1:0]  rk_idx,
    output logic [127:0]         rk_out
);
    localparam int DEPTH = 4 * (MAX_NK + 7);
    localparam int AW    = $clog2(DEPTH);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [1:0] {IDLE, LOAD, GEN, FIN} state_t;

    state_t              state_reg, state_next;
    logic                busy_reg, busy_next, done_reg, done_next;
    logic                valid_reg, valid_next, err_reg, err_next;
    logic [3:0]          nr_reg, nr_next, nk_reg, nk_next;
    logic [AW-1:0]       idx_reg, idx_next;
    logic [2:0]          sub_reg, sub_next;
    logic [7:0]          rcon_reg, rcon_next;
    logic [32*MAX_NK-1:0] key_reg, key_next;

    logic [31:0]         w_mem [DEPTH];
    logic [31:0]         prev_word, back_word, sbox_in, sbox_out, gen_word;
    logic [3:0]          req_nk, req_nr;
    logic                req_ok;

    // Key lengths beyond the configured storage are rejected like key_len=3.
    always_comb begin
        req_nk = 4'd4;
        req_nr = 4'd10;
        req_ok = 1'b1;
        case (key_len)
            2'd0:    begin req_nk = 4'd4; req_nr = 4'd10; end
            2'd1:    begin req_nk = 4'd6; req_nr = 4'd12; end
            2'd2:    begin req_nk = 4'd8; req_nr = 4'd14; end
            default: req_ok = 1'b0;
        endcase
        if (int'(req_nk) > MAX_NK)
            req_ok = 1'b0;
    end

    // sub_reg tracks i mod NK; position 0 uses RotWord+rcon, position 4 (NK=8) plain SubWord.
    assign prev_word = w_mem[idx_reg - AW'(1)];
    assign back_word = w_mem[idx_reg - AW'(nk_reg)];
    assign sbox_in   = (sub_reg == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    assign sbox_out  = sub_word(sbox_in);

    always_comb begin
        if (sub_reg == 3'd0)
            gen_word = sbox_out ^ {rcon_reg, 24'h0} ^ back_word;
        else if (nk_reg == 4'd8 && sub_reg == 3'd4)
            gen_word = sbox_out ^ back_word;
        else
            gen_word = prev_word ^ back_word;
    end

    always_comb begin
        state_next = state_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        valid_next = valid_reg;
        err_next   = err_reg;
        nr_next    = nr_reg;
        nk_next    = nk_reg;
        idx_next   = idx_reg;
        sub_next   = sub_reg;
        rcon_next  = rcon_reg;
        key_next   = key_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (req_ok) begin
                        state_next = LOAD;
                        busy_next  = 1'b1;
                        valid_next = 1'b0;
                        err_next   = 1'b0;
                        nr_next    = req_nr;
                        nk_next    = req_nk;
                        key_next   = key;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_next = GEN;
                idx_next   = AW'(nk_reg);
                sub_next   = 3'd0;
            end
            GEN: begin
                idx_next = idx_reg + AW'(1);
                sub_next = (sub_reg == 3'(nk_reg - 4'd1)) ? 3'd0 : sub_reg + 3'd1;
                if (sub_reg == 3'd0)
                    rcon_next = xtime(rcon_reg);
                if (idx_reg == AW'({nr_reg, 2'b11})) begin
                    state_next = FIN;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    valid_next = 1'b1;
                end
            end
            FIN: begin
                state_next = IDLE;
                rcon_next  = 8'h01;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            nr_reg    <= '0;
            nk_reg    <= '0;
            idx_reg   <= '0;
            sub_reg   <= '0;
            rcon_reg  <= 8'h01;
            key_reg   <= '0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
            nr_reg    <= nr_next;
            nk_reg    <= nk_next;
            idx_reg   <= idx_next;
            sub_reg   <= sub_next;
            rcon_reg  <= rcon_next;
            key_reg   <= key_next;
        end
    end

    // Key bits are numbered MSB-first, so word 0 occupies the top 32 bits of key.
    always_ff @(posedge clk) begin
        if (state_reg == LOAD) begin
            for (int k = 0; k < MAX_NK; k++)
                if (k < int'(nk_reg))
                    w_mem[AW'(k)] <= key_reg[32*(MAX_NK-k)-1 -: 32];
        end else if (state_reg == GEN) begin
            w_mem[idx_reg] <= gen_word;
        end
    end

    logic [127:0] rk_fwd;
    logic         rd_ok;

    assign rd_ok = valid_reg && (int'(rk_idx) <= int'(nr_reg));

    for (genvar gi = 0; gi < 4; gi++) begin : g_col
        logic [AW-1:0] ridx;
        assign ridx = AW'({rk_idx, 2'(gi)});
        assign rk_fwd[127-32*gi -: 32] = w_mem[ridx];
    end

`ifdef AES_KS_INV_KEYS_EN
    function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? b : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    logic [127:0] rk_imc;
    logic         use_inv;

    for (genvar gi = 0; gi < 4; gi++) begin : g_imc
        logic [7:0] a0, a1, a2, a3;
        assign {a0, a1, a2, a3} = rk_fwd[127-32*gi -: 32];
        assign rk_imc[127-32*gi -: 32] = {
            gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
            gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
            gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
            gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
    end

    // First and last round keys feed AddRoundKey directly in the equivalent inverse cipher.
    assign use_inv = rk_inv && (rk_idx != '0) && (int'(rk_idx) < int'(nr_reg));
    assign rk_out  = !rd_ok ? '0 : (use_inv ? rk_imc : rk_fwd);
`else
    assign rk_out = rd_ok ? rk_fwd : '0;
`endif

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign key_valid = valid_reg;
    assign err       = err_reg;
    assign nr        = nr_reg;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Self-checking bench for aes_key_schedule_seq: FIPS-197 vectors plus random keys checked
// against an arithmetic AES key-expansion model (S-box derived from GF(2^8) inverse + affine map).
module tb_aes_key_schedule_seq;
    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         busy, done, key_valid, err;
    logic [3:0]   nr;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
`ifdef AES_KS_INV_KEYS_EN
    logic         rk_inv;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0]  sbox_m [256];
    logic [31:0] exp_w [60];
    int          exp_nr = 0;

    always #5 clk = ~clk;

    aes_key_schedule_seq #(.MAX_NK(8), .RK_IDX_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key),
        .busy(busy), .done(done), .key_valid(key_valid), .err(err), .nr(nr),
`ifdef AES_KS_INV_KEYS_EN
        .rk_inv(rk_inv),
`endif
        .rk_idx(rk_idx), .rk_out(rk_out));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw_m(input logic [31:0] x);
        return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
    endfunction

    task automatic model_expand(input int nk, input logic [255:0] k);
        logic [7:0]  rc;
        logic [31:0] t;
        rc = 8'h01;
        exp_nr = nk + 6;
        for (int i = 0; i < nk; i++) exp_w[i] = k[255-32*i -: 32];
        for (int i = nk; i < 4*(exp_nr+1); i++) begin
            t = exp_w[i-1];
            if (i % nk == 0) begin
                t = subw_m({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw_m(t);
            end
            exp_w[i] = exp_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] exp_rk(input int r);
        if (r > exp_nr) return '0;
        return {exp_w[4*r], exp_w[4*r+1], exp_w[4*r+2], exp_w[4*r+3]};
    endfunction

    function automatic logic [127:0] model_imc(input logic [127:0] s);
        logic [127:0] res;
        logic [7:0]   m [4];
        logic [7:0]   b;
        m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++)
                    b = b ^ gmul(s[127-32*c-8*j -: 8], m[(j - row + 4) % 4]);
                res[127-32*c-8*row -: 8] = b;
            end
        return res;
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int n = 0; n < 8; n++) k[32*n +: 32] = $urandom;
        return k;
    endfunction

    function automatic int exp_latency(input int nk);
        return 1 + 1 + (4*(nk+7) - nk) + 1;
    endfunction

    // Drives one start pulse; lat is the cycle (start cycle = 1) in which done is seen, capped at 200.
    task automatic run_expand(input logic [1:0] kl, input logic [255:0] k, output int lat);
        @(negedge clk);
        key_len = kl; key = k; start = 1'b1;
        lat = 1;
        do begin
            @(negedge clk);
            start = 1'b0;
            key = rand_key();
            key_len = 2'($urandom);
            lat++;
        end while (!done && lat < 200);
        $display("expansion key_len=%0d latency=%0d nr=%0d", kl, lat, nr);
    endtask

    task automatic test_reset();
        start = 1'b0; key_len = 2'd0; key = '0; rk_idx = '0;
`ifdef AES_KS_INV_KEYS_EN
        rk_inv = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, key_valid, err, nr} !== 8'h00) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00000000", {busy, done, key_valid, err, nr});
        end
        rst = 1'b0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk); rk_idx = 4'(r * 5); #1;
            checks++;
            if (rk_out !== '0) begin
                failures++;
                $display("FAIL reset_rk idx=%0d got=%h want=0", r * 5, rk_out);
            end
        end
    endtask

    task automatic test_aes128();
        int lat;
        logic [255:0] k;
        k = rand_key();
        k[255:128] = K128;
        model_expand(4, k);
        run_expand(2'd0, k, lat);
        checks++;
        if (lat != 43) begin failures++; $display("FAIL lat128 got=%0d want=43", lat); end
        @(negedge clk);
        checks++;
        if ({done, busy, key_valid, nr} !== {3'b001, 4'd10}) begin
            failures++;
            $display("FAIL status128 got=%b want=0011010", {done, busy, key_valid, nr});
        end
        rk_idx = 4'd1; #1;
        checks++;
        if (rk_out !== R1) begin failures++; $display("FAIL rk1_128 got=%h want=%h", rk_out, R1); end
        @(negedge clk); rk_idx = 4'd10; #1;
        checks++;
        if (rk_out !== R10) begin failures++; $display("FAIL rk10_128 got=%h want=%h", rk_out, R10); end
        for (int r = 0; r < 16; r++) begin
            @(negedge clk); rk_idx = 4'(r); #1;
            checks++;
            if (rk_out !== exp_rk(r)) begin
                failures++;
                $display("FAIL model128 idx=%0d got=%h want=%h", r, rk_out, exp_rk(r));
            end
        end
    endtask

    task automatic test_illegal_len();
        int dones, lat;
        @(negedge clk);
        key_len = 2'd3; key = rand_key(); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({err, busy, key_valid, nr} !== {3'b101, 4'd10}) begin
            failures++;
            $display("FAIL illegal_status got=%b want=1011010", {err, busy, key_valid, nr});
        end
        rk_idx = 4'd10; #1;
        checks++;
        if (rk_out !== R10) begin failures++; $display("FAIL illegal_rk10 got=%h want=%h", rk_out, R10); end
        dones = 0;
        repeat (6) begin @(negedge clk); if (done || busy) dones++; end
        checks++;
        if (dones != 0) begin failures++; $display("FAIL illegal_activity got=%0d want=0", dones); end
        $display("illegal start key_len=3 err=%0b", err);
        run_expand(2'd0, K256, lat);
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL illegal_err_clear got=%0b want=0", err); end
    endtask

    task automatic test_aes192();
        int lat;
        logic [255:0] k;
        k = rand_key();
        k[255:64] = K192;
        model_expand(6, k);
        run_expand(2'd1, k, lat);
        checks++;
        if (lat != exp_latency(6)) begin failures++; $display("FAIL lat192 got=%0d want=%0d", lat, exp_latency(6)); end
        @(negedge clk); rk_idx = 4'd12; #1;
        checks++;
        if (nr !== 4'd12) begin failures++; $display("FAIL nr192 got=%0d want=12", nr); end
        checks++;
        if (rk_out[31:0] !== 32'h01002202) begin
            failures++;
            $display("FAIL rk12_192 got=%h want=01002202", rk_out[31:0]);
        end
        for (int r = 0; r < 16; r++) begin
            @(negedge clk); rk_idx = 4'(r); #1;
            checks++;
            if (rk_out !== exp_rk(r)) begin
                failures++;
                $display("FAIL model192 idx=%0d got=%h want=%h", r, rk_out, exp_rk(r));
            end
        end
    endtask

    task automatic test_aes256();
        int lat;
        model_expand(8, K256);
        run_expand(2'd2, K256, lat);
        checks++;
        if (lat != exp_latency(8)) begin failures++; $display("FAIL lat256 got=%0d want=%0d", lat, exp_latency(8)); end
        @(negedge clk); rk_idx = 4'd14; #1;
        checks++;
        if (nr !== 4'd14) begin failures++; $display("FAIL nr256 got=%0d want=14", nr); end
        checks++;
        if (rk_out[31:0] !== 32'h706c631e) begin
            failures++;
            $display("FAIL rk14_256 got=%h want=706c631e", rk_out[31:0]);
        end
        @(negedge clk); rk_idx = 4'd15; #1;
        checks++;
        if (rk_out !== '0) begin failures++; $display("FAIL rk15_256 got=%h want=0", rk_out); end
        for (int r = 0; r < 15; r++) begin
            @(negedge clk); rk_idx = 4'(r); #1;
            checks++;
            if (rk_out !== exp_rk(r)) begin
                failures++;
                $display("FAIL model256 idx=%0d got=%h want=%h", r, rk_out, exp_rk(r));
            end
        end
    endtask

    task automatic test_random();
        int lat, nk;
        logic [1:0] kl;
        logic [255:0] k;
        for (int t = 0; t < 8; t++) begin
            kl = 2'($urandom_range(0, 2));
            nk = 4 + 2 * int'(kl);
            k = rand_key();
            model_expand(nk, k);
            run_expand(kl, k, lat);
            checks++;
            if (lat != exp_latency(nk) || nr !== 4'(nk + 6)) begin
                failures++;
                $display("FAIL random_timing t=%0d lat=%0d nr=%0d want lat=%0d nr=%0d", t, lat, nr, exp_latency(nk), nk + 6);
            end
            for (int r = 0; r < 16; r++) begin
                @(negedge clk); rk_idx = 4'(r); #1;
                checks++;
                if (rk_out !== exp_rk(r)) begin
                    failures++;
                    $display("FAIL random_rk t=%0d idx=%0d got=%h want=%h", t, r, rk_out, exp_rk(r));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones, first;
        logic [255:0] ka;
        ka = rand_key();
        model_expand(6, ka);
        @(negedge clk);
        key_len = 2'd1; key = ka; start = 1'b1;
        dones = 0; first = 0;
        for (int c = 2; c <= 120; c++) begin
            @(negedge clk);
            if (done) begin dones++; if (first == 0) first = c; end
            start = (c <= 44) ? 1'($urandom) : 1'b0;
            key_len = 2'd0;
            key = rand_key();
        end
        $display("busy-start run dones=%0d first_done=%0d", dones, first);
        checks++;
        if (dones != 1 || first != exp_latency(6)) begin
            failures++;
            $display("FAIL busy_start dones=%0d at=%0d want 1 at %0d", dones, first, exp_latency(6));
        end
        checks++;
        if ({err, key_valid, nr} !== {2'b01, 4'd12}) begin
            failures++;
            $display("FAIL busy_start_status got=%b want=011100", {err, key_valid, nr});
        end
        for (int r = 0; r < 16; r++) begin
            @(negedge clk); rk_idx = 4'(r); #1;
            checks++;
            if (rk_out !== exp_rk(r)) begin
                failures++;
                $display("FAIL busy_start_rk idx=%0d got=%h want=%h", r, rk_out, exp_rk(r));
            end
        end
    endtask

    task automatic test_reset_abort();
        int lat, act;
        logic [255:0] k;
        k = rand_key();
        k[255:128] = K128;
        model_expand(4, k);
        @(negedge clk);
        key_len = 2'd0; key = k; start = 1'b1;
        for (int c = 2; c <= 22; c++) begin @(negedge clk); start = 1'b0; end
        rst = 1'b1;
        @(negedge clk);
        rk_idx = 4'd1; #1;
        checks++;
        if ({busy, done, key_valid, err, nr} !== 8'h00) begin
            failures++;
            $display("FAIL abort_flags got=%b want=00000000", {busy, done, key_valid, err, nr});
        end
        checks++;
        if (rk_out !== '0) begin failures++; $display("FAIL abort_rk got=%h want=0", rk_out); end
        rst = 1'b0;
        act = 0;
        repeat (60) begin @(negedge clk); if (done || busy) act++; end
        checks++;
        if (act != 0) begin failures++; $display("FAIL abort_activity got=%0d want=0", act); end
        $display("reset abort at GEN cycle 20");
        run_expand(2'd0, k, lat);
        checks++;
        if (lat != 43) begin failures++; $display("FAIL abort_restart_lat got=%0d want=43", lat); end
        for (int r = 0; r < 16; r++) begin
            @(negedge clk); rk_idx = 4'(r); #1;
            checks++;
            if (rk_out !== exp_rk(r)) begin
                failures++;
                $display("FAIL abort_restart_rk idx=%0d got=%h want=%h", r, rk_out, exp_rk(r));
            end
        end
    endtask

`ifdef AES_KS_INV_KEYS_EN
    task automatic test_inv_keys();
        logic [127:0] want;
        rk_inv = 1'b1;
        for (int r = 0; r < 12; r++) begin
            @(negedge clk); rk_idx = 4'(r); #1;
            want = (r >= 1 && r <= 9) ? model_imc(exp_rk(r)) : exp_rk(r);
            checks++;
            if (rk_out !== want) begin
                failures++;
                $display("FAIL inv_rk idx=%0d got=%h want=%h", r, rk_out, want);
            end
        end
        @(negedge clk); rk_idx = 4'd0; #1;
        checks++;
        if (rk_out !== K128) begin failures++; $display("FAIL inv_rk0 got=%h want=%h", rk_out, K128); end
        rk_inv = 1'b0;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        build_sbox();
        test_reset();
        test_aes128();
        test_illegal_len();
        test_aes192();
        test_aes256();
        test_random();
        test_back_to_back();
        test_reset_abort();
`ifdef AES_KS_INV_KEYS_EN
        test_inv_keys();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
